// File: rtl/javk_fetch_pkg.sv
// Shared definitions for the JAVK instruction fetch unit and its consumers (ctrl).
// Holds the state encodings, the opcode length-field layout and the instruction payload type.
package javk_fetch_pkg;

    localparam int unsigned PC_W   = 16;
    localparam int unsigned DATA_W = 8;

    // Opcode bits that carry the instruction length code.
    localparam int unsigned ILEN_HI      = 7;
    localparam int unsigned ILEN_LO      = 6;
    localparam int unsigned ILEN_FIELD_W = ILEN_HI - ILEN_LO + 1;
    localparam int unsigned NBYTES_W     = 2;

    localparam logic [ILEN_FIELD_W-1:0] ILEN_1   = 2'b00;
    localparam logic [ILEN_FIELD_W-1:0] ILEN_2   = 2'b01;
    localparam logic [ILEN_FIELD_W-1:0] ILEN_3   = 2'b10;
    localparam logic [ILEN_FIELD_W-1:0] ILEN_RSV = 2'b11;

    typedef enum logic [1:0] {
        FETCH_S_OP   = 2'd0,
        FETCH_S_A    = 2'd1,
        FETCH_S_B    = 2'd2,
        FETCH_S_HOLD = 2'd3
    } fetch_state_e;

    // Complete instruction as handed to ctrl.
    typedef struct packed {
        logic [PC_W-1:0]   ipc;
        logic [DATA_W-1:0] instr;
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
    } fetch_instr_t;

endpackage

// File: rtl/javk_fetch_ilen_dec.sv
// Maps the opcode length field to the instruction byte count (1..3).
// The reserved code decodes as a single byte; ctrl deals with its meaning.
module javk_fetch_ilen_dec
    import javk_fetch_pkg::*;
(
    input  logic [ILEN_FIELD_W-1:0] i_len_field,
    output logic [NBYTES_W-1:0]     o_nbytes_c
);

    always_comb begin
        o_nbytes_c = NBYTES_W'(1);
        case (i_len_field)
            ILEN_2:  o_nbytes_c = NBYTES_W'(2);
            ILEN_3:  o_nbytes_c = NBYTES_W'(3);
            default: o_nbytes_c = NBYTES_W'(1);
        endcase
    end

endmodule

// File: rtl/javk_fetch.sv
// JAVK instruction fetch: reads one byte per granted bus cycle, assembles a
// 1/2/3-byte instruction and hands it to ctrl over a valid/ready handshake.
module javk_fetch
    import javk_fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_gnt,
    output logic [PC_W-1:0]   addr,
    output logic              rd,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ld,
    input  logic [PC_W-1:0]   ld_pc,
    output logic [DATA_W-1:0] instr,
    output logic [DATA_W-1:0] opa,
    output logic [DATA_W-1:0] opb,
    output logic [PC_W-1:0]   ipc,
    output logic              valid,
    input  logic              ready
);

    fetch_state_e        r_state;
    fetch_state_e        w_state_nxt;
    logic [PC_W-1:0]     r_pc;
    logic [PC_W-1:0]     w_pc_nxt;
    fetch_instr_t        r_ins;
    fetch_instr_t        w_ins_nxt;
    logic [NBYTES_W-1:0] w_len_new;
    logic [NBYTES_W-1:0] w_len_cur;

    // Length of the opcode on the bus (S_OP) and of the one already captured (S_A).
    javk_fetch_ilen_dec u_len_new (
        .i_len_field (rdata[ILEN_HI:ILEN_LO]),
        .o_nbytes_c  (w_len_new)
    );

    javk_fetch_ilen_dec u_len_cur (
        .i_len_field (r_ins.instr[ILEN_HI:ILEN_LO]),
        .o_nbytes_c  (w_len_cur)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= FETCH_S_OP;
            r_pc        <= RESET_PC;
            r_ins.ipc   <= RESET_PC;
            r_ins.instr <= '0;
            r_ins.opa   <= '0;
            r_ins.opb   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_ins   <= w_ins_nxt;
        end
    end

    // A load overrides any capture or handshake in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ins_nxt   = r_ins;
        if (ld) begin
            w_state_nxt = FETCH_S_OP;
            w_pc_nxt    = ld_pc;
        end else begin
            case (r_state)
                FETCH_S_OP: begin
                    if (bus_gnt) begin
                        w_ins_nxt.instr = rdata;
                        w_ins_nxt.ipc   = r_pc;
                        w_ins_nxt.opa   = '0;
                        w_ins_nxt.opb   = '0;
                        w_pc_nxt        = r_pc + PC_W'(1);
                        w_state_nxt     = (w_len_new == NBYTES_W'(1)) ? FETCH_S_HOLD : FETCH_S_A;
                    end
                end
                FETCH_S_A: begin
                    if (bus_gnt) begin
                        w_ins_nxt.opa = rdata;
                        w_pc_nxt      = r_pc + PC_W'(1);
                        w_state_nxt   = (w_len_cur == NBYTES_W'(3)) ? FETCH_S_B : FETCH_S_HOLD;
                    end
                end
                FETCH_S_B: begin
                    if (bus_gnt) begin
                        w_ins_nxt.opb = rdata;
                        w_pc_nxt      = r_pc + PC_W'(1);
                        w_state_nxt   = FETCH_S_HOLD;
                    end
                end
                FETCH_S_HOLD: begin
                    if (ready) begin
                        w_state_nxt = FETCH_S_OP;
                    end
                end
                default: w_state_nxt = FETCH_S_OP;
            endcase
        end
    end

    assign addr  = r_pc;
    assign rd    = rst & (r_state != FETCH_S_HOLD);
    assign valid = (r_state == FETCH_S_HOLD);
    assign instr = r_ins.instr;
    assign opa   = r_ins.opa;
    assign opb   = r_ins.opb;
    assign ipc   = r_ins.ipc;

endmodule

// File: tb/tb_javk_fetch.sv
// Bench for javk_fetch: directed scenarios plus randomized bus/handshake/load
// traffic, checked against a transaction-level model of the fetch sequence.
module tb_javk_fetch;

    logic        clk;
    logic        rst;
    logic        bus_gnt;
    logic [15:0] addr;
    logic        rd;
    logic [7:0]  rdata;
    logic        ld;
    logic [15:0] ld_pc;
    logic [7:0]  instr;
    logic [7:0]  opa;
    logic [7:0]  opb;
    logic [15:0] ipc;
    logic        valid;
    logic        ready;

    logic [7:0]  mem [0:65535];

    int n_vec;
    int n_err;

    // Model: start address of the current instruction, bytes captured so far, length.
    logic [15:0] m_pc;
    int          m_got;
    int          m_len;
    bit          m_hold;

    javk_fetch #(.RESET_PC(16'h0000)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus_gnt (bus_gnt),
        .addr    (addr),
        .rd      (rd),
        .rdata   (rdata),
        .ld      (ld),
        .ld_pc   (ld_pc),
        .instr   (instr),
        .opa     (opa),
        .opb     (opb),
        .ipc     (ipc),
        .valid   (valid),
        .ready   (ready)
    );

    assign rdata = mem[addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int len_of(input logic [7:0] op);
        int code;
        code = int'(op) / 64;
        if (code == 1) return 2;
        if (code == 2) return 3;
        return 1;
    endfunction

    task automatic model_reset();
        m_pc   = 16'h0000;
        m_got  = 0;
        m_len  = 1;
        m_hold = 0;
    endtask

    // One rising edge of the reference, from the inputs the bench applied.
    task automatic model_step();
        if (!rst) begin
            model_reset();
        end else if (ld) begin
            m_pc   = ld_pc;
            m_got  = 0;
            m_hold = 0;
        end else if (m_hold) begin
            if (ready) begin
                m_pc   = 16'(m_pc + m_len);
                m_got  = 0;
                m_hold = 0;
            end
        end else if (bus_gnt) begin
            if (m_got == 0) m_len = len_of(mem[m_pc]);
            m_got++;
            if (m_got == m_len) m_hold = 1;
        end
    endtask

    task automatic check_outputs();
        logic [15:0] exp_addr;
        logic [15:0] a1;
        logic [15:0] a2;
        exp_addr = m_hold ? 16'(m_pc + m_len) : 16'(m_pc + m_got);
        a1 = 16'(m_pc + 1);
        a2 = 16'(m_pc + 2);
        chk("valid", 32'(valid), 32'(m_hold));
        chk("rd", 32'(rd), 32'(rst && !m_hold));
        chk("addr", 32'(addr), 32'(exp_addr));
        if (m_hold) begin
            chk("instr", 32'(instr), 32'(mem[m_pc]));
            chk("opa", 32'(opa), (m_len >= 2) ? 32'(mem[a1]) : 32'h0);
            chk("opb", 32'(opb), (m_len == 3) ? 32'(mem[a2]) : 32'h0);
            chk("ipc", 32'(ipc), 32'(m_pc));
        end
    endtask

    // Starts and ends at a falling edge.
    task automatic cycle(input bit g, input bit r, input bit l, input logic [15:0] lp);
        bus_gnt = g;
        ready   = r;
        ld      = l;
        ld_pc   = lp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_outputs();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst     = 1'b0;
        bus_gnt = 1'b0;
        ready   = 1'b0;
        ld      = 1'b0;
        ld_pc   = 16'h0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        model_reset();

        // Reset and 1-byte fetch
        mem[16'h0000] = 8'h05;
        @(negedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_rd", 32'(rd), 32'h0);
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_instr", 32'(instr), 32'h0);
        chk("rst_opa", 32'(opa), 32'h0);
        chk("rst_opb", 32'(opb), 32'h0);
        chk("rst_ipc", 32'(ipc), 32'h0);
        rst = 1'b1;
        cycle(1, 1, 0, 16'h0);
        chk("t1_instr", 32'(instr), 32'h05);
        chk("t1_valid", 32'(valid), 32'h1);
        cycle(1, 1, 0, 16'h0);
        chk("t1_addr", 32'(addr), 32'h0001);

        // 3-byte instruction held for five cycles
        mem[16'h0010] = 8'h8A;
        mem[16'h0011] = 8'h34;
        mem[16'h0012] = 8'h12;
        cycle(1, 0, 1, 16'h0010);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 16'h0);
        chk("t2_opb", 32'(opb), 32'h12);
        for (int i = 0; i < 5; i++) cycle(1, 0, 0, 16'h0);
        cycle(1, 1, 0, 16'h0);
        chk("t2_addr", 32'(addr), 32'h0013);

        // Bus contention between opcode and operand
        mem[16'h0020] = 8'h41;
        mem[16'h0021] = 8'h99;
        cycle(1, 0, 1, 16'h0020);
        cycle(1, 0, 0, 16'h0);
        cycle(0, 0, 0, 16'h0);
        cycle(0, 0, 0, 16'h0);
        chk("t3_not_yet", 32'(valid), 32'h0);
        cycle(1, 0, 0, 16'h0);
        chk("t3_opa", 32'(opa), 32'h99);
        cycle(1, 1, 0, 16'h0);

        // Flush during operand fetch
        mem[16'h0030] = 8'h41;
        mem[16'h2000] = 8'h05;
        cycle(1, 1, 1, 16'h0030);
        cycle(1, 1, 0, 16'h0);
        cycle(1, 1, 1, 16'h2000);
        chk("t4_flush_valid", 32'(valid), 32'h0);
        chk("t4_flush_addr", 32'(addr), 32'h2000);
        cycle(1, 0, 0, 16'h0);
        chk("t4_ipc", 32'(ipc), 32'h2000);
        cycle(1, 1, 0, 16'h0);

        // PC wrap
        mem[16'hFFFF] = 8'h80;
        mem[16'h0000] = 8'hAA;
        mem[16'h0001] = 8'hBB;
        cycle(1, 0, 1, 16'hFFFF);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 16'h0);
        chk("t5_ipc", 32'(ipc), 32'hFFFF);
        chk("t5_opa", 32'(opa), 32'hAA);
        cycle(1, 1, 0, 16'h0);
        chk("t5_addr", 32'(addr), 32'h0002);

        // Randomized traffic, including loads that coincide with acceptance
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 4000; i++) begin
            cycle(($urandom_range(0, 3) != 0), 1'($urandom), ($urandom_range(0, 19) == 0),
                  16'($urandom));
        end

        // Asynchronous reset while in S_B
        mem[16'h4000] = 8'h80;
        cycle(1, 0, 1, 16'h4000);
        cycle(1, 0, 0, 16'h0);
        cycle(1, 0, 0, 16'h0);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        chk("ar_valid", 32'(valid), 32'h0);
        chk("ar_rd", 32'(rd), 32'h0);
        chk("ar_addr", 32'(addr), 32'h0);
        chk("ar_instr", 32'(instr), 32'h0);
        chk("ar_opa", 32'(opa), 32'h0);
        chk("ar_opb", 32'(opb), 32'h0);
        chk("ar_ipc", 32'(ipc), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1, 1, 0, 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
